rvfpm_xif_queue: RTL
====================

Name: rvfpm_xif_queue

Overview:
- Synthesizable, parametrised XIF instruction queue for the rvfpm coprocessor. It replaces the behavioural accept/commit bookkeeping with cycle-accurate RTL.
- Buffers accepted issue transactions together with their operands, and matches out-of-order commit/kill messages to queued entries by XIF id.
- Releases only committed, non-killed instructions, in program order, to the FPU execution pipeline.
- Sits between the CORE-V-XIF issue/commit interfaces and the pipeline dispatch port.

Parameters:
- QUEUE_DEPTH, 4, number of entries; power of two, >= 2.
- X_ID_WIDTH, 4, width of XIF instruction id.
- X_NUM_RS, 3, number of source operands per entry.
- FLEN, 32, operand width.

Ports:
- ck  input  1  clock
- rst  input  1  synchronous reset, active-high
- flush  input  1  synchronous clear of all entries
- issue_valid  input  1  XIF issue request valid
- issue_ready  output  1  queue can take an entry
- issue_accept  input  1  predecoder accepts the instruction (combinational, same cycle)
- issue_instr  input  32  instruction word
- issue_id  input  X_ID_WIDTH  XIF id
- issue_rs  input  X_NUM_RS*FLEN  operands; rs[i] at [i*FLEN +: FLEN]
- issue_mode  input  2  privilege mode
- commit_valid  input  1  commit message valid
- commit_id  input  X_ID_WIDTH  id being committed or killed
- commit_kill  input  1  1 = kill, 0 = commit
- disp_valid  output  1  head entry ready for execution
- disp_ready  input  1  pipeline takes head
- disp_instr  output  32  head instruction
- disp_id  output  X_ID_WIDTH  head id
- disp_rs  output  X_NUM_RS*FLEN  head operands
- disp_mode  output  2  head mode
- occupancy  output  $clog2(QUEUE_DEPTH+1)  valid entry count
- commit_miss  output  1  one-cycle pulse: commit/kill id matched nothing
- kill_drop  output  1  one-cycle pulse: killed head entry discarded

Behaviour:
- Reset and flush are identical in effect and sampled at posedge ck. All entries invalid, pointers 0, occupancy 0, disp_valid 0, commit_miss 0, kill_drop 0, issue_ready 1 on the following cycle. Flush overrides same-cycle issue, commit and dispatch.
- Entry state machine, per slot:
  - FREE -> PEND on enqueue.
  - PEND -> COMMITTED on a commit with kill=0.
  - PEND -> KILLED on a commit with kill=1.
  - COMMITTED -> FREE on dispatch handshake.
  - KILLED -> FREE on auto-drain.
- issue_ready = !full. It is not combinationally dependent on disp_ready, so there is no full-queue bypass.
- Enqueue occurs when issue_valid & issue_ready & issue_accept. Data is written at the tail and the tail increments mod QUEUE_DEPTH. With issue_valid & !issue_accept, nothing is stored.
- Commit match rule: the oldest entry in PEND with equal id, searched from head. Entries in COMMITTED or KILLED never match.
- Same-cycle issue and commit with the same id, with no PEND match in the queue: the state is applied to the entering entry, which is written directly as COMMITTED or KILLED.
- No match anywhere: commit_miss = 1 the next cycle; no state change.
- Head handling:
  - Head COMMITTED: disp_valid = 1, disp_* are registered entry fields, and head advances on disp_ready.
  - Head KILLED: discarded in one cycle without asserting disp_valid; kill_drop pulses the next cycle.
  - Head PEND or FREE: disp_valid = 0. Younger committed entries wait behind it, so dispatch is strictly in order.
- disp_* hold stable while disp_valid & !disp_ready.
- occupancy = entries not FREE. Simultaneous enqueue and dequeue/drain leaves occupancy unchanged. It saturates at neither end, because full/empty gating prevents overflow and underflow.
- Pointers are $clog2(QUEUE_DEPTH) bits and wrap naturally. Full/empty are derived from occupancy.
- Latency from enqueue with commit in the same cycle to disp_valid, with the queue empty, is 1 cycle.

Decomposition:
- Shared package pa_rvfpm gains:
  - an entry state enum (FREE, PEND, COMMITTED, KILLED);
  - a typedef for the entry struct (instr, id, rs array, mode, state).
- One sub-module, rvfpm_xif_id_match: a combinational oldest-first priority match of commit_id against PEND entries, rotated from head. It returns a hit flag and an index.

Test Plan:
- Reset/flush: issue ids 1,2, then assert flush -> occupancy 0, disp_valid 0, issue_ready 1 next cycle; a later commit id 1 -> commit_miss pulse.
- In-order flow: DEPTH 4. Issue ids 3,5,7, then commit 3,5,7 -> dispatch order 3,5,7, disp_rs matching the values driven at issue (e.g. 0x3F800000).
- Out-of-order commit: issue ids 1,2. Commit 2 first -> disp_valid stays 0. Then commit 1 -> dispatch 1 then 2 on consecutive cycles with disp_ready = 1.
- Kill: issue ids 4,6; kill 4, commit 6 -> kill_drop pulses once, only id 6 is dispatched, occupancy reaches 0.
- Full and backpressure: fill 4 entries with disp_ready = 0 -> issue_ready 0, fifth issue not stored. Commit head and raise disp_ready -> issue_ready 1 the next cycle. A further 4 wrap-around enqueues preserve order.
- Simultaneous issue+commit and duplicate ids: issue id 9 with commit_valid id 9 in the same cycle -> entry written COMMITTED, disp_valid next cycle. Two queued id 2 entries plus commit 2 -> only the older is committed.

Source files
------------

// File: rtl/pa_rvfpm.sv
// Shared rvfpm coprocessor types: XIF queue entry state and entry layout.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package pa_rvfpm;

    // Default geometry of the XIF queue; the queue module exposes these as parameters.
    localparam int XQ_DEPTH_DEF    = 4;
    localparam int XQ_ID_WIDTH_DEF = 4;
    localparam int XQ_NUM_RS_DEF   = 3;
    localparam int XQ_FLEN_DEF     = 32;

    // Lifecycle of one queue slot.
    typedef enum logic [1:0] {
        ENT_FREE      = 2'd0,
        ENT_PEND      = 2'd1,
        ENT_COMMITTED = 2'd2,
        ENT_KILLED    = 2'd3
    } xif_entry_state_e;

    // Queue entry layout at the default geometry.
    typedef struct packed {
        logic [31:0]                                    instr;
        logic [XQ_ID_WIDTH_DEF-1:0]                     id;
        logic [XQ_NUM_RS_DEF-1:0][XQ_FLEN_DEF-1:0]      rs;
        logic [1:0]                                     mode;
        xif_entry_state_e                               state;
    } xif_entry_t;

endpackage

// File: rtl/rvfpm_xif_id_match.sv
// Finds the oldest PEND entry whose XIF id equals the commit id, scanning from head.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module rvfpm_xif_id_match
    import pa_rvfpm::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int X_ID_WIDTH  = 4,
    localparam int PW         = $clog2(QUEUE_DEPTH)
) (
    input  logic [2*QUEUE_DEPTH-1:0]          i_state,
    input  logic [QUEUE_DEPTH*X_ID_WIDTH-1:0] i_id,
    input  logic [PW-1:0]                     i_head,
    input  logic [X_ID_WIDTH-1:0]             i_commit_id,
    output logic                              o_hit,
    output logic [PW-1:0]                     o_idx
);

    logic [PW-1:0] w_slot;

    // Walk slots in age order starting at head; the first PEND id match wins.
    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        w_slot = '0;
        for (int k = 0; k < QUEUE_DEPTH; k++) begin
            w_slot = i_head + PW'(k);
            if (!o_hit
                && (i_state[2*w_slot +: 2] == ENT_PEND)
                && (i_id[X_ID_WIDTH*w_slot +: X_ID_WIDTH] == i_commit_id)) begin
                o_hit = 1'b1;
                o_idx = w_slot;
            end
        end
    end

endmodule

// File: rtl/rvfpm_xif_queue.sv
// XIF issue queue: holds accepted instructions, resolves commit/kill by id, dispatches committed ones in order.
// Latency: issue+commit in the same cycle on an empty queue -> disp_valid one cycle later.
// Backpressure: issue_ready = !full (no bypass); head holds while disp_valid & !disp_ready.
module rvfpm_xif_queue
    import pa_rvfpm::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_NUM_RS    = 3,
    parameter int FLEN        = 32
) (
    input  logic                               ck,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               issue_valid,
    output logic                               issue_ready,
    input  logic                               issue_accept,
    input  logic [31:0]                        issue_instr,
    input  logic [X_ID_WIDTH-1:0]              issue_id,
    input  logic [X_NUM_RS*FLEN-1:0]           issue_rs,
    input  logic [1:0]                         issue_mode,
    input  logic                               commit_valid,
    input  logic [X_ID_WIDTH-1:0]              commit_id,
    input  logic                               commit_kill,
    output logic                               disp_valid,
    input  logic                               disp_ready,
    output logic [31:0]                        disp_instr,
    output logic [X_ID_WIDTH-1:0]              disp_id,
    output logic [X_NUM_RS*FLEN-1:0]           disp_rs,
    output logic [1:0]                         disp_mode,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   occupancy,
    output logic                               commit_miss,
    output logic                               kill_drop
);

    localparam int PW  = $clog2(QUEUE_DEPTH);
    localparam int OW  = $clog2(QUEUE_DEPTH+1);
    localparam int RSW = X_NUM_RS*FLEN;

    xif_entry_state_e        r_state [QUEUE_DEPTH];
    logic [31:0]             r_instr [QUEUE_DEPTH];
    logic [X_ID_WIDTH-1:0]   r_id    [QUEUE_DEPTH];
    logic [RSW-1:0]          r_rs    [QUEUE_DEPTH];
    logic [1:0]              r_mode  [QUEUE_DEPTH];
    logic [PW-1:0]           r_head;
    logic [PW-1:0]           r_tail;
    logic [OW-1:0]           r_occ;
    logic                    r_commit_miss;
    logic                    r_kill_drop;

    logic [2*QUEUE_DEPTH-1:0]          w_state_flat;
    logic [QUEUE_DEPTH*X_ID_WIDTH-1:0] w_id_flat;
    logic                              w_hit;
    logic [PW-1:0]                     w_match_idx;
    logic                              w_full;
    logic                              w_enq;
    logic                              w_enq_match;
    logic                              w_deq;
    logic                              w_drain;
    logic                              w_head_out;
    xif_entry_state_e                  w_resolved;
    xif_entry_state_e                  w_enq_state;
    logic [OW-1:0]                     w_occ_nxt;

    // Flatten slot state and ids for the matcher.
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            w_state_flat[2*i +: 2]                 = r_state[i];
            w_id_flat[X_ID_WIDTH*i +: X_ID_WIDTH]  = r_id[i];
        end
    end

    rvfpm_xif_id_match #(
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .X_ID_WIDTH  (X_ID_WIDTH)
    ) u_id_match (
        .i_state     (w_state_flat),
        .i_id        (w_id_flat),
        .i_head      (r_head),
        .i_commit_id (commit_id),
        .o_hit       (w_hit),
        .o_idx       (w_match_idx)
    );

    assign w_full      = (r_occ == OW'(QUEUE_DEPTH));
    assign issue_ready = !w_full;
    assign w_enq       = issue_valid && issue_ready && issue_accept;
    // A commit that finds no queued PEND entry may target the instruction entering this cycle.
    assign w_enq_match = w_enq && commit_valid && !w_hit && (issue_id == commit_id);
    assign w_resolved  = commit_kill ? ENT_KILLED : ENT_COMMITTED;
    assign w_enq_state = w_enq_match ? w_resolved : ENT_PEND;

    assign disp_valid  = (r_state[r_head] == ENT_COMMITTED);
    assign w_deq       = disp_valid && disp_ready;
    assign w_drain     = (r_state[r_head] == ENT_KILLED);
    assign w_head_out  = w_deq || w_drain;

    assign disp_instr  = r_instr[r_head];
    assign disp_id     = r_id[r_head];
    assign disp_rs     = r_rs[r_head];
    assign disp_mode   = r_mode[r_head];
    assign occupancy   = r_occ;
    assign commit_miss = r_commit_miss;
    assign kill_drop   = r_kill_drop;

    // Occupancy moves by at most one per cycle; enqueue and removal together cancel.
    always_comb begin
        w_occ_nxt = r_occ;
        if (w_enq && !w_head_out) begin
            w_occ_nxt = r_occ + OW'(1);
        end else if (!w_enq && w_head_out) begin
            w_occ_nxt = r_occ - OW'(1);
        end
    end

    // Slot state machine, pointers, occupancy and status pulses; reset and flush clear everything.
    always_ff @(posedge ck) begin
        if (rst || flush) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_state[i] <= ENT_FREE;
            end
            r_head        <= '0;
            r_tail        <= '0;
            r_occ         <= '0;
            r_commit_miss <= 1'b0;
            r_kill_drop   <= 1'b0;
        end else begin
            // Tail slot is FREE whenever enqueue is possible, and commits only touch PEND
            // slots while the head only leaves from COMMITTED/KILLED, so these never collide.
            if (w_enq) begin
                r_state[r_tail] <= w_enq_state;
                r_tail          <= r_tail + PW'(1);
            end
            if (commit_valid && w_hit) begin
                r_state[w_match_idx] <= w_resolved;
            end
            if (w_head_out) begin
                r_state[r_head] <= ENT_FREE;
                r_head          <= r_head + PW'(1);
            end
            r_occ         <= w_occ_nxt;
            r_commit_miss <= commit_valid && !w_hit && !w_enq_match;
            r_kill_drop   <= w_drain;
        end
    end

    // Entry payload is only meaningful while the slot is not FREE, so it needs no reset.
    always_ff @(posedge ck) begin
        if (w_enq) begin
            r_instr[r_tail] <= issue_instr;
            r_id[r_tail]    <= issue_id;
            r_rs[r_tail]    <= issue_rs;
            r_mode[r_tail]  <= issue_mode;
        end
    end

endmodule
